// File: rtl/crossbar_sched_4x4.sv
// Slot scheduler for a 4x4 crossbar built from five 2x2 pass/swap elements.
// Optional per-input grant counters are enabled with `define XBAR_STATS_EN.
module crossbar_sched_4x4 #(
  parameter int SLOT_LEN = 4,
  parameter int PTR_W    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_valid,
  input  logic [7:0] req_dest,
  output logic [3:0] req_ready,
  output logic [4:0] xbar_ctrl,
  output logic [3:0] out_valid,
  output logic       busy
`ifdef XBAR_STATS_EN
  ,
  output logic [63:0] grant_cnt
`endif
);

  localparam int CNT_W = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [3:0][1:0]  dst;

  for (genvar i = 0; i < 4; i++) begin : g_dst
    assign dst[i] = req_dest[2*i +: 2];
  end

  // Round-robin greedy pick: the per-pair limits keep the set routable.
  logic [3:0]       grant, used;
  logic             a_r, b_l, found, is_a;
  logic [PTR_W-1:0] idx, first;
  logic [1:0]       d;

  always_comb begin
    grant = '0;
    used  = '0;
    a_r   = 1'b0;
    b_l   = 1'b0;
    found = 1'b0;
    first = ptr;
    idx   = ptr;
    d     = '0;
    is_a  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx  = ptr + PTR_W'(k);
      d    = dst[idx];
      is_a = ~idx[1];
      if (req_valid[idx] && !used[d] && !(is_a && d[1] && a_r) && !(!is_a && !d[1] && b_l)) begin
        grant[idx] = 1'b1;
        used[d]    = 1'b1;
        if (is_a && d[1])   a_r = 1'b1;
        if (!is_a && !d[1]) b_l = 1'b1;
        if (!found) begin
          found = 1'b1;
          first = idx;
        end
      end
    end
  end

  // Element settings for the chosen set.
  logic       a0l, a0r, a1l, a1r, b2l, b2r, b3l, b3r;
  logic [1:0] a_up, a_lo, b_up, b_lo, mid_l, mid_r;
  logic [4:0] ctrl_nxt;

  always_comb begin
    a0l = grant[0] & ~dst[0][1];
    a0r = grant[0] &  dst[0][1];
    a1l = grant[1] & ~dst[1][1];
    a1r = grant[1] &  dst[1][1];
    b2l = grant[2] & ~dst[2][1];
    b2r = grant[2] &  dst[2][1];
    b3l = grant[3] & ~dst[3][1];
    b3r = grant[3] &  dst[3][1];
    ctrl_nxt    = '0;
    ctrl_nxt[2] = a0r | a1r | b2l | b3l;
    ctrl_nxt[0] = a0r | (~a0l & a1l);
    ctrl_nxt[3] = b3l | (~b3r & b2r);
    a_up  = ctrl_nxt[0] ? 2'd1 : 2'd0;
    a_lo  = ctrl_nxt[0] ? 2'd0 : 2'd1;
    b_up  = ctrl_nxt[3] ? 2'd3 : 2'd2;
    b_lo  = ctrl_nxt[3] ? 2'd2 : 2'd3;
    mid_l = ctrl_nxt[2] ? b_up : a_lo;
    mid_r = ctrl_nxt[2] ? a_lo : b_up;
    ctrl_nxt[1] = (grant[mid_l] && dst[mid_l] == 2'd0) || (grant[a_up] && dst[a_up] == 2'd1);
    ctrl_nxt[4] = (grant[b_lo] && dst[b_lo] == 2'd2) || (grant[mid_r] && dst[mid_r] == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = HOLD;
      HOLD:    if (cnt == CNT_W'(SLOT_LEN - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      cnt       <= '0;
      req_ready <= '0;
      xbar_ctrl <= '0;
      out_valid <= '0;
    end else begin
      req_ready <= '0;
      if (state == IDLE) begin
        if (|grant) begin
          req_ready <= grant;
          xbar_ctrl <= ctrl_nxt;
          out_valid <= used;
          ptr       <= first + 1'b1;
          cnt       <= '0;
        end
      end else if (cnt == CNT_W'(SLOT_LEN - 1)) begin
        xbar_ctrl <= '0;
        out_valid <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef XBAR_STATS_EN
  logic [3:0][15:0] stat_cnt;
  for (genvar i = 0; i < 4; i++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   stat_cnt[i] <= '0;
      else if (req_ready[i] && stat_cnt[i] != '1)   stat_cnt[i] <= stat_cnt[i] + 1'b1;
    end
  end
  assign grant_cnt = stat_cnt;
`endif

endmodule

// File: tb/tb_crossbar_sched_4x4.sv
// Directed bench for crossbar_sched_4x4: reset, routing patterns, conflicts,
// round-robin rotation and slot timing, asynchronous reset during a slot.
module tb_crossbar_sched_4x4;
  localparam int SLOT_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [7:0] req_dest;
  logic [3:0] req_ready;
  logic [4:0] xbar_ctrl;
  logic [3:0] out_valid;
  logic       busy;
`ifdef XBAR_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  crossbar_sched_4x4 #(.SLOT_LEN(SLOT_LEN), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dest(req_dest),
    .req_ready(req_ready), .xbar_ctrl(xbar_ctrl),
    .out_valid(out_valid), .busy(busy)
`ifdef XBAR_STATS_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applied just after an edge, so it never coincides with sampling.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == 4'b0 && n < 20);
  endtask

  logic [4:0] fair_ctrl [5];
  int         n;

  initial begin
    fair_ctrl[0] = 5'b10101;
    fair_ctrl[1] = 5'b10100;
    fair_ctrl[2] = 5'b01000;
    fair_ctrl[3] = 5'b00000;
    fair_ctrl[4] = 5'b10101;

    rst_n     = 1'b0;
    req_valid = '0;
    req_dest  = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ctrl",  32'(xbar_ctrl), 32'h0);
    chk("rst_ov",    32'(out_valid), 32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_req", 32'(busy), 32'h0);

    // identity
    req_valid = 4'hF; req_dest = 8'hE4;
    tick();
    chk("id_ready", 32'(req_ready), 32'hF);
    chk("id_ctrl",  32'(xbar_ctrl), 32'h00);
    chk("id_ov",    32'(out_valid), 32'hF);
    chk("id_busy",  32'(busy),      32'h1);
    req_valid = 4'h0;
    tick();
    chk("id_ready_pulse", 32'(req_ready), 32'h0);
    tick(); tick();
    chk("id_busy_last", 32'(busy),      32'h1);
    chk("id_ov_held",   32'(out_valid), 32'hF);
    tick();
    chk("id_busy_end", 32'(busy),      32'h0);
    chk("id_ov_end",   32'(out_valid), 32'h0);

    // blocked permutation
    pulse_reset();
    req_valid = 4'hF; req_dest = 8'h4E;
    tick();
    chk("perm1_ready", 32'(req_ready), 32'b0101);
    chk("perm1_ctrl",  32'(xbar_ctrl), 32'b00111);
    chk("perm1_ov",    32'(out_valid), 32'b0101);
    req_valid = 4'b1010;
    wait_grant(n);
    chk("perm2_gap",   32'(n),         32'(SLOT_LEN + 1));
    chk("perm2_ready", 32'(req_ready), 32'b1010);
    chk("perm2_ctrl",  32'(xbar_ctrl), 32'b11100);
    chk("perm2_ov",    32'(out_valid), 32'b1010);
    req_valid = 4'h0;

    // output conflict: 0 and 1 both to output 1
    pulse_reset();
    req_valid = 4'b0011; req_dest = 8'h05;
    tick();
    chk("conf1_ready", 32'(req_ready), 32'b0001);
    chk("conf1_ctrl",  32'(xbar_ctrl), 32'b00010);
    chk("conf1_ov",    32'(out_valid), 32'b0010);
    req_valid = 4'b0010;
    wait_grant(n);
    chk("conf2_ready", 32'(req_ready), 32'b0010);
    chk("conf2_ctrl",  32'(xbar_ctrl), 32'b00011);
    chk("conf2_ov",    32'(out_valid), 32'b0010);
    req_valid = 4'h0;

    // round-robin: everyone wants output 3
    pulse_reset();
    req_valid = 4'hF; req_dest = 8'hFF;
    for (int s = 0; s < 5; s++) begin
      wait_grant(n);
      chk("rr_gap",   32'(n),         (s == 0) ? 32'd1 : 32'(SLOT_LEN + 1));
      chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (s % 4)));
      chk("rr_ctrl",  32'(xbar_ctrl), 32'(fair_ctrl[s]));
      chk("rr_ov",    32'(out_valid), 32'b1000);
    end
    req_valid = 4'h0;
    repeat (SLOT_LEN) tick();

    // reset in the middle of a slot
    req_valid = 4'hF; req_dest = 8'hE4;
    tick();
    tick();
    chk("mid_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_ctrl",  32'(xbar_ctrl), 32'h0);
    chk("mid_ov",    32'(out_valid), 32'h0);
    chk("mid_busy",  32'(busy),      32'h0);
    chk("mid_ready", 32'(req_ready), 32'h0);
    req_dest = 8'hFF;
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    chk("post_rst_ctrl",  32'(xbar_ctrl), 32'b10101);
    req_valid = 4'h0;

`ifdef XBAR_STATS_EN
    pulse_reset();
    req_valid = 4'b0100; req_dest = 8'h00;
    for (int s = 0; s < 5; s++) wait_grant(n);
    req_valid = 4'h0;
    tick();
    chk("stat_in2", 32'(grant_cnt[47:32]), 32'd5);
    chk("stat_in0", 32'(grant_cnt[15:0]),  32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
